operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Pipeline stage between decode and execute that sits directly upstream of the processor register file.
- Drives register-file read addresses, captures both operands, and bypasses same-cycle writeback data, because the register file writes on the clock edge.
- A per-register pending-write scoreboard stalls RAW/WAW hazards.
- Presents a registered valid/ready operand bundle to execute.

Parameters:
- D, 5, register address width (2^D registers)
- W, 32, operand/data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  decode presents instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1  in  D  source register 1
- in_rs2  in  D  source register 2
- in_rd  in  D  destination register
- in_rd_we  in  1  instruction writes in_rd
- rf_addr1  out  D  register file read address 1
- rf_addr2  out  D  register file read address 2
- rf_rdata1  in  W  register file read data 1
- rf_rdata2  in  W  register file read data 2
- wb_valid  in  1  writeback retiring this cycle (same signal drives register file write_enable)
- wb_rd  in  D  writeback destination
- wb_data  in  W  writeback data
- flush  in  1  discard the held instruction
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts bundle
- out_op1  out  W  operand 1
- out_op2  out  W  operand 2
- out_rd  out  D  destination
- out_rd_we  out  1  destination write enable
- stall  out  1  hazard stall indicator (in_valid && !in_ready)

Behaviour:
- Reset (rst==0 at posedge):
  - out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_rd_we=0.
  - All pending bits cleared.
  - Reset mid-operation discards the held bundle; no pending bits survive.
- rf_addr1=in_rs1 and rf_addr2=in_rs2, combinational, regardless of in_valid.
- Register 0 is the zero register:
  - Operand for rs==0 is 0.
  - Register 0 is never pending.
  - in_rd_we with in_rd==0 sets nothing.
- Effective pending: eff_pend[r] = pend[r] && !(wb_valid && wb_rd==r).
- hazard = eff_pend[in_rs1] || eff_pend[in_rs2] || (in_rd_we && eff_pend[in_rd]), with index-0 terms forced 0.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready), at posedge:
  - out_valid=1, out_rd=in_rd, out_rd_we=in_rd_we.
  - out_opN = 0 if rsN==0; else wb_data if wb_valid && wb_rd==rsN; else rf_rdataN.
  - pend[in_rd] set if in_rd_we && in_rd!=0.
- Latency: one cycle from accept to out_valid.
- Output held stable while out_valid && !out_ready.
- Dispatch (out_valid && out_ready) without new accept: out_valid=0 next cycle. Pending bit remains until writeback.
- Dispatch and accept in the same cycle: back-to-back, out_valid stays 1 with the new bundle.
- Writeback: wb_valid clears pend[wb_rd] at posedge.
  - If the same cycle's accept sets the same register, the set wins (bit ends 1).
- flush:
  - Sets out_valid=0 next cycle.
  - If out_valid && out_rd_we && out_rd!=0, clears pend[out_rd], since the flushed instruction never writes back.
  - A set from the same cycle is impossible, because in_ready=0 during flush.
  - flush overrides out_ready: the bundle is dropped, not dispatched.
- Only one write may be outstanding per register (enforced by the WAW term).
- Writeback to a non-pending register is legal and clears nothing harmful.
- stall is combinational.

Test Plan:
- Reset then idle:
  - Hold rst=0 for 2 cycles, release.
  - Required: out_valid=0, in_ready=1, all pending=0.
- Simple issue:
  - rf_rdata1=0x11, rf_rdata2=0x22, rs1=3, rs2=4, rd=5, we=1, out_ready=1.
  - Required: next cycle out_op1=0x11, out_op2=0x22, out_rd=5.
  - Required: a following instruction reading r5 stalls until wb_valid with wb_rd=5.
- Same-cycle bypass:
  - r5 pending; in_rs1=5 while wb_valid=1, wb_rd=5, wb_data=0xDEAD, rf_rdata1=0x0.
  - Required: accepted that cycle; out_op1=0xDEAD; pend[5]=0 afterwards unless the new rd==5, in which case pend[5]=1.
- Backpressure:
  - out_ready=0 for 3 cycles with the bundle held.
  - Required: outputs unchanged, in_ready=0.
  - Required: out_ready=1 plus a new in_valid gives back-to-back transfer with no bubble.
- Zero register:
  - rs1=0, rf_rdata1=0xFFFF_FFFF, rd=0, we=1.
  - Required: out_op1=0; no pending bit set; the next instruction reading r0 is not stalled.
- Flush:
  - Bundle with rd=7, we=1 held, out_ready=0; assert flush.
  - Required: out_valid=0 next cycle and pend[7]=0; an instruction reading r7 is accepted immediately.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: sits between decode and execute, directly upstream of
// the register file. Drives read addresses, captures both operands (bypassing
// same-cycle writeback because the register file writes on the clock edge),
// tracks outstanding destination writes in a per-register scoreboard, and
// presents a registered valid/ready bundle to execute.
//
// Register 0 is hardwired to zero: it is never pending and always reads 0.
module operand_fetch_stage #(
    parameter int D = 5,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] in_rs1,
    input  logic [D-1:0] in_rs2,
    input  logic [D-1:0] in_rd,
    input  logic         in_rd_we,
    output logic [D-1:0] rf_addr1,
    output logic [D-1:0] rf_addr2,
    input  logic [W-1:0] rf_rdata1,
    input  logic [W-1:0] rf_rdata2,
    input  logic         wb_valid,
    input  logic [D-1:0] wb_rd,
    input  logic [W-1:0] wb_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_op1,
    output logic [W-1:0] out_op2,
    output logic [D-1:0] out_rd,
    output logic         out_rd_we,
    output logic         stall
);

    localparam int NREG = 1 << D;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [NREG-1:0] eff_pend;
    logic            hazard;
    logic            accept;
    logic [W-1:0]    op1_nxt;
    logic [W-1:0]    op2_nxt;

    // Zero register reads as 0; a retiring write to the same register is
    // forwarded since the register file has not captured it yet.
    function automatic logic [W-1:0] pick_operand(
        input logic [D-1:0] rs,
        input logic [W-1:0] rdata,
        input logic         wbv,
        input logic [D-1:0] wbr,
        input logic [W-1:0] wbd
    );
        if (rs == '0)
            return '0;
        else if (wbv && (wbr == rs))
            return wbd;
        else
            return rdata;
    endfunction

    assign rf_addr1 = in_rs1;
    assign rf_addr2 = in_rs2;

    // Pending bits as seen this cycle: a retiring writeback already resolves its hazard.
    always_comb begin
        eff_pend = '0;
        for (int r = 1; r < NREG; r++) begin
            eff_pend[r] = pend[r] && !(wb_valid && (wb_rd == D'(r)));
        end
    end

    // RAW on either source, WAW on the destination, then the handshake.
    always_comb begin
        hazard = 1'b0;
        if ((in_rs1 != '0) && eff_pend[in_rs1])
            hazard = 1'b1;
        if ((in_rs2 != '0) && eff_pend[in_rs2])
            hazard = 1'b1;
        if (in_rd_we && (in_rd != '0) && eff_pend[in_rd])
            hazard = 1'b1;
    end

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready;

    assign op1_nxt = pick_operand(in_rs1, rf_rdata1, wb_valid, wb_rd, wb_data);
    assign op2_nxt = pick_operand(in_rs2, rf_rdata2, wb_valid, wb_rd, wb_data);

    // Scoreboard update; ordering makes a same-cycle set win over a writeback clear.
    always_comb begin
        pend_nxt = pend;
        if (wb_valid)
            pend_nxt[wb_rd] = 1'b0;
        // A flushed instruction will never write back, so release its destination.
        if (flush && out_valid && out_rd_we)
            pend_nxt[out_rd] = 1'b0;
        if (accept && in_rd_we)
            pend_nxt[in_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    // Output bundle: flush drops it, accept loads it, dispatch alone empties it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= op1_nxt;
            out_op2   <= op2_nxt;
            out_rd    <= in_rd;
            out_rd_we <= in_rd_we;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage. Inputs change 1 ns after the rising
// edge; combinational outputs are sampled 1 ns later, registered outputs 1 ns
// after the following edge.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_we;
    logic [4:0]  rf_addr1, rf_addr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_fetch_stage #(.D(5), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .rf_addr1  (rf_addr1),
        .rf_addr2  (rf_addr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we),
        .stall     (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    int busy;

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        rf_rdata1 = 32'h0;
        rf_rdata2 = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset then idle
        tick();
        tick();
        rst = 1'b1;
        settle();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_op1", out_op1, 32'd0);
        check("rst_out_rd", {27'b0, out_rd}, 32'd0);
        check("rst_out_rd_we", {31'b0, out_rd_we}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        busy = 0;
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 5'(r), 5'(r), 5'(r), 1'b1);
            #1;
            if (!in_ready) busy++;
        end
        check("rst_no_pending", busy, 0);
        drive(1'b0, 5'd9, 5'd12, 5'd0, 1'b0);
        settle();
        check("rf_addr1", {27'b0, rf_addr1}, 32'd9);
        check("rf_addr2", {27'b0, rf_addr2}, 32'd12);

        // Simple issue
        rf_rdata1 = 32'h11;
        rf_rdata2 = 32'h22;
        drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
        settle();
        check("issue_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b0);
        settle();
        check("issue_out_valid", {31'b0, out_valid}, 32'd1);
        check("issue_op1", out_op1, 32'h11);
        check("issue_op2", out_op2, 32'h22);
        check("issue_rd", {27'b0, out_rd}, 32'd5);
        check("issue_rd_we", {31'b0, out_rd_we}, 32'd1);
        check("raw_stall_c0", {31'b0, stall}, 32'd1);
        tick();
        check("dispatch_empties", {31'b0, out_valid}, 32'd0);
        check("raw_stall_c1", {31'b0, stall}, 32'd1);
        tick();
        check("raw_stall_c2", {31'b0, in_ready}, 32'd0);

        // Same-cycle bypass, new rd differs
        rf_rdata1 = 32'h0;
        wb(1'b1, 5'd5, 32'hDEAD);
        settle();
        check("bypass_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
        settle();
        check("bypass_op1", out_op1, 32'hDEAD);
        check("bypass_rd", {27'b0, out_rd}, 32'd6);
        check("bypass_rd_we", {31'b0, out_rd_we}, 32'd0);
        check("bypass_pend5_clear", {31'b0, in_ready}, 32'd1);

        // Same-cycle bypass, new rd equals the retiring register
        rf_rdata1 = 32'h1;
        rf_rdata2 = 32'h2;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
        wb(1'b1, 5'd5, 32'hBEEF);
        settle();
        check("bypass2_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
        settle();
        check("bypass2_op1", out_op1, 32'hBEEF);
        check("bypass2_pend5_set", {31'b0, in_ready}, 32'd0);
        wb(1'b1, 5'd5, 32'h0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        settle();
        check("wb_clears_pend5", {31'b0, in_ready}, 32'd1);

        // Backpressure
        out_ready = 1'b0;
        rf_rdata1 = 32'h33;
        rf_rdata2 = 32'h44;
        drive(1'b1, 5'd3, 5'd4, 5'd8, 1'b0);
        tick();
        rf_rdata1 = 32'h55;
        rf_rdata2 = 32'h66;
        drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b0);
        settle();
        for (int c = 0; c < 3; c++) begin
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_stall", {31'b0, stall}, 32'd1);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_op1", out_op1, 32'h33);
            check("bp_op2", out_op2, 32'h44);
            check("bp_rd", {27'b0, out_rd}, 32'd8);
            tick();
        end
        out_ready = 1'b1;
        settle();
        check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("b2b_out_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_op1", out_op1, 32'h55);
        check("b2b_op2", out_op2, 32'h66);
        check("b2b_rd", {27'b0, out_rd}, 32'd9);
        tick();
        check("b2b_drain", {31'b0, out_valid}, 32'd0);

        // Zero register
        rf_rdata1 = 32'hFFFF_FFFF;
        rf_rdata2 = 32'hFFFF_FFFF;
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        settle();
        check("zero_op1", out_op1, 32'd0);
        check("zero_op2", out_op2, 32'd0);
        check("zero_rd_we", {31'b0, out_rd_we}, 32'd1);
        check("zero_no_stall", {31'b0, in_ready}, 32'd1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Flush
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
        tick();
        drive(1'b0, 5'd7, 5'd0, 5'd0, 1'b0);
        settle();
        check("flush_held", {31'b0, out_valid}, 32'd1);
        check("flush_held_rd", {27'b0, out_rd}, 32'd7);
        flush = 1'b1;
        settle();
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        rf_rdata1 = 32'h77;
        drive(1'b1, 5'd7, 5'd0, 5'd10, 1'b0);
        settle();
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_pend7_clear", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("post_flush_valid", {31'b0, out_valid}, 32'd1);
        check("post_flush_op1", out_op1, 32'h77);

        // Reset mid-operation
        out_ready = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 5'd11, 1'b1);
        tick();
        drive(1'b0, 5'd11, 5'd0, 5'd0, 1'b0);
        settle();
        check("pre_rst_pend11", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_pend11", {31'b0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
